// File: rtl/manycore_mesh_tile_node.sv
// manycore_mesh_tile_node
//   One tile of the manycore mesh. It contains a 5-port XY-routed packet router
//   with ports P(0), W(1), E(2), N(3) and S(4), and it relays the tile's reset and
//   coordinate daisy-chain from the north neighbour to the south neighbour.
// Ports
//   clk_i, reset_i            clock, synchronous active-high reset from the north
//   reset_o                   reset_i delayed one cycle, to the south tile
//   global_x_i/global_y_i     coordinates from the north
//   global_x_o/global_y_o     latched X and latched Y+1, to the south
//   link_v_i/link_data_i      per-direction input packets; link_ready_o = FIFO not full
//   link_v_o/link_data_o      per-direction output packets; link_ready_i = downstream ready
//   Packet layout is {data, dest_y, dest_x} with dest_x in the LSBs.
module manycore_mesh_tile_node #(
  parameter int unsigned x_cord_width_p = 7,
  parameter int unsigned y_cord_width_p = 7,
  parameter int unsigned data_width_p   = 32,
  parameter int unsigned fifo_els_p     = 2,
  localparam int unsigned pkt_width_lp  = data_width_p + y_cord_width_p + x_cord_width_p
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  output logic                      reset_o,
  input  logic [x_cord_width_p-1:0] global_x_i,
  input  logic [y_cord_width_p-1:0] global_y_i,
  output logic [x_cord_width_p-1:0] global_x_o,
  output logic [y_cord_width_p-1:0] global_y_o,
  input  logic [4:0]                link_v_i,
  input  logic [5*pkt_width_lp-1:0] link_data_i,
  output logic [4:0]                link_ready_o,
  output logic [4:0]                link_v_o,
  output logic [5*pkt_width_lp-1:0] link_data_o,
  input  logic [4:0]                link_ready_i
);

  localparam int unsigned NumPorts = 5;
  localparam int unsigned PtrW     = $clog2(fifo_els_p);
  localparam int unsigned CntW     = $clog2(fifo_els_p + 1);
  localparam int unsigned XW       = x_cord_width_p;
  localparam int unsigned YW       = y_cord_width_p;

  typedef struct packed {
    logic [data_width_p-1:0] data;
    logic [YW-1:0]           dest_y;
    logic [XW-1:0]           dest_x;
  } pkt_t;

  logic          reset_r_q;
  logic [XW-1:0] my_x_q;
  logic [YW-1:0] my_y_q;
  logic [YW-1:0] y_out_q;

  pkt_t [NumPorts-1:0] in_pkt;
  pkt_t [NumPorts-1:0] head;
  pkt_t [NumPorts-1:0] out_pkt;
  logic [NumPorts-1:0] head_v;
  logic [NumPorts-1:0] full;
  logic [NumPorts-1:0] deq;
  logic [NumPorts-1:0] out_v;
  logic [NumPorts-1:0] xfer;
  logic [NumPorts-1:0][NumPorts-1:0] req;   // req[input][output]

  logic [NumPorts-1:0][2:0] win;
  logic [NumPorts-1:0][2:0] ptr_q, ptr_d;
  logic [NumPorts-1:0]      lock_q, lock_d;
  logic [NumPorts-1:0][2:0] lock_idx_q;

  assign in_pkt = link_data_i;

  // Reset pipeline and coordinate latch; reset_r_q is the tile-internal reset.
  always_ff @(posedge clk_i) begin
    reset_r_q <= reset_i;
    if (reset_r_q) begin
      my_x_q  <= global_x_i;
      my_y_q  <= global_y_i;
      y_out_q <= global_y_i + YW'(1);
    end
  end

  assign reset_o    = reset_r_q;
  assign global_x_o = my_x_q;
  assign global_y_o = y_out_q;

  // Ready comes from occupancy only, masked while the tile is in reset.
  assign link_ready_o = ~full & {NumPorts{~reset_r_q}};

  // Per-input FIFOs.
  for (genvar i = 0; i < NumPorts; i++) begin : g_fifo
    pkt_t            mem_q [fifo_els_p];
    logic [PtrW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            enq;

    assign enq = link_v_i[i] & link_ready_o[i];

    always_comb begin
      rd_d  = rd_q;
      wr_d  = wr_q;
      if (enq) wr_d = (wr_q == PtrW'(fifo_els_p - 1)) ? '0 : wr_q + PtrW'(1);
      if (deq[i]) rd_d = (rd_q == PtrW'(fifo_els_p - 1)) ? '0 : rd_q + PtrW'(1);
      cnt_d = cnt_q + CntW'(enq) - CntW'(deq[i]);
    end

    always_ff @(posedge clk_i) begin
      if (reset_r_q) begin
        rd_q  <= '0;
        wr_q  <= '0;
        cnt_q <= '0;
      end else begin
        rd_q  <= rd_d;
        wr_q  <= wr_d;
        cnt_q <= cnt_d;
      end
    end

    // Storage needs no reset; occupancy alone decides validity.
    always_ff @(posedge clk_i) begin
      if (enq) mem_q[wr_q] <= in_pkt[i];
    end

    assign head[i]   = mem_q[rd_q];
    assign head_v[i] = (cnt_q != '0);
    assign full[i]   = (cnt_q == CntW'(fifo_els_p));
  end

  // XY route of each FIFO head, one-hot over outputs.
  always_comb begin
    req = '0;
    for (int i = 0; i < NumPorts; i++) begin
      if (head_v[i]) begin
        if (head[i].dest_x < my_x_q)      req[i][1] = 1'b1;
        else if (head[i].dest_x > my_x_q) req[i][2] = 1'b1;
        else if (head[i].dest_y < my_y_q) req[i][3] = 1'b1;
        else if (head[i].dest_y > my_y_q) req[i][4] = 1'b1;
        else                              req[i][0] = 1'b1;
      end
    end
  end

  // Round-robin output arbiters. A stalled grant is locked so the presented
  // packet stays stable even if a higher-priority head shows up meanwhile.
  always_comb begin : arb_comb
    logic [2:0] idx;
    logic       found;
    idx    = 3'd0;
    found  = 1'b0;
    win    = '0;
    out_v  = '0;
    xfer   = '0;
    deq    = '0;
    ptr_d  = ptr_q;
    lock_d = '0;
    for (int o = 0; o < NumPorts; o++) begin
      found  = 1'b0;
      win[o] = ptr_q[o];
      if (lock_q[o]) begin
        found  = 1'b1;
        win[o] = lock_idx_q[o];
      end else begin
        for (int k = 0; k < NumPorts; k++) begin
          idx = 3'((int'(ptr_q[o]) + k) % NumPorts);
          if (!found && req[idx][o]) begin
            found  = 1'b1;
            win[o] = idx;
          end
        end
      end
      out_v[o]  = found & ~reset_r_q;
      xfer[o]   = out_v[o] & link_ready_i[o];
      lock_d[o] = out_v[o] & ~link_ready_i[o];
      if (xfer[o]) begin
        deq[win[o]] = 1'b1;
        ptr_d[o]    = (win[o] == 3'd4) ? 3'd0 : win[o] + 3'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_r_q) begin
      ptr_q      <= '0;
      lock_q     <= '0;
      lock_idx_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      lock_q     <= lock_d;
      lock_idx_q <= win;
    end
  end

  always_comb begin
    out_pkt = '0;
    for (int o = 0; o < NumPorts; o++) begin
      out_pkt[o] = head[win[o]];
    end
  end

  assign link_v_o    = out_v;
  assign link_data_o = out_pkt;

endmodule

// File: tb/tb_manycore_mesh_tile_node.sv
// Directed bench for manycore_mesh_tile_node: reset/coordinate chain, routing
// table, round-robin fairness, backpressure, coordinate wrap and mid-run reset.
module tb_manycore_mesh_tile_node;

  localparam int PW = 46;
  localparam int PP = 0, PWst = 1, PE = 2, PN = 3, PS = 4;

  logic           clk;
  logic           reset_i;
  logic           reset_o;
  logic [6:0]     gx_i, gy_i, gx_o, gy_o;
  logic [4:0]     link_v_i, link_ready_o, link_v_o, link_ready_i;
  logic [5*PW-1:0] link_data_i, link_data_o;

  int n_vec  = 0;
  int n_fail = 0;

  manycore_mesh_tile_node dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .reset_o      (reset_o),
    .global_x_i   (gx_i),
    .global_y_i   (gy_i),
    .global_x_o   (gx_o),
    .global_y_o   (gy_o),
    .link_v_i     (link_v_i),
    .link_data_i  (link_data_i),
    .link_ready_o (link_ready_o),
    .link_v_o     (link_v_o),
    .link_data_o  (link_data_o),
    .link_ready_i (link_ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    int          in_port;
    logic [6:0]  dx;
    logic [6:0]  dy;
    logic [31:0] data;
    int          out_port;
  } vec_t;

  vec_t tbl[12];

  function automatic logic [PW-1:0] mk(input logic [31:0] d, input logic [6:0] y, input logic [6:0] x);
    return {d, y, x};
  endfunction

  function automatic logic [PW-1:0] out_data(input int port);
    return link_data_o[port*PW +: PW];
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input int port, input logic [PW-1:0] pkt);
    link_data_i[port*PW +: PW] = pkt;
    link_v_i[port] = 1'b1;
  endtask

  // Leaves the bench at the negedge right after the internal reset has fallen.
  task automatic do_reset(input logic [6:0] x, input logic [6:0] y);
    @(negedge clk);
    link_v_i = '0;
    reset_i  = 1'b1;
    gx_i     = x;
    gy_i     = y;
    @(negedge clk);
    reset_i = 1'b0;
    @(negedge clk);
  endtask

  logic [4:0]    oh;
  logic [PW-1:0] pkt;
  logic [PW-1:0] rr_exp[6];
  logic [PW-1:0] bp[4];

  initial begin
    // Tile (3,2) routing vectors: ports P0 W1 E2 N3 S4.
    tbl[0]  = '{PWst, 7'd5,   7'd2,   32'h1111_0000, PE};
    tbl[1]  = '{PWst, 7'd1,   7'd2,   32'h1111_0001, PWst};
    tbl[2]  = '{PWst, 7'd3,   7'd0,   32'h1111_0002, PN};
    tbl[3]  = '{PWst, 7'd3,   7'd4,   32'h1111_0003, PS};
    tbl[4]  = '{PWst, 7'd3,   7'd2,   32'h1111_0004, PP};
    tbl[5]  = '{PP,   7'd127, 7'd0,   32'h2222_0005, PE};
    tbl[6]  = '{PE,   7'd0,   7'd127, 32'h3333_0006, PWst};
    tbl[7]  = '{PN,   7'd3,   7'd127, 32'h4444_0007, PS};
    tbl[8]  = '{PS,   7'd3,   7'd1,   32'h5555_0008, PN};
    tbl[9]  = '{PE,   7'd4,   7'd2,   32'h3333_0009, PE};
    tbl[10] = '{PP,   7'd3,   7'd2,   32'h2222_000A, PP};
    tbl[11] = '{PN,   7'd2,   7'd5,   32'h4444_000B, PWst};

    reset_i      = 1'b1;
    gx_i         = 7'd3;
    gy_i         = 7'd2;
    link_v_i     = '0;
    link_data_i  = '0;
    link_ready_i = 5'h1f;

    // Reset chain: three reset cycles, then release.
    @(negedge clk);
    chk("reset_o_follows", 64'(reset_o), 64'd1);
    @(negedge clk);
    @(negedge clk);
    reset_i = 1'b0;
    #1;
    chk("ready_in_reset", 64'(link_ready_o), 64'h0);
    chk("reset_o_trails", 64'(reset_o), 64'd1);
    @(negedge clk);
    chk("reset_o_low", 64'(reset_o), 64'd0);
    chk("ready_after_reset", 64'(link_ready_o), 64'h1f);
    chk("v_after_reset", 64'(link_v_o), 64'h0);
    chk("global_x_o", 64'(gx_o), 64'd3);
    chk("global_y_o", 64'(gy_o), 64'd3);

    // Routing table: one packet at a time, visible one cycle after acceptance.
    for (int i = 0; i < 12; i++) begin
      pkt = mk(tbl[i].data, tbl[i].dy, tbl[i].dx);
      oh  = 5'b1 << tbl[i].out_port;
      chk($sformatf("vec%0d_ready", i), 64'(link_ready_o[tbl[i].in_port]), 64'd1);
      drive(tbl[i].in_port, pkt);
      @(negedge clk);
      link_v_i = '0;
      chk($sformatf("vec%0d_v", i), 64'(link_v_o), 64'(oh));
      chk($sformatf("vec%0d_data", i), 64'(out_data(tbl[i].out_port)), 64'(pkt));
      @(negedge clk);
      chk($sformatf("vec%0d_drained", i), 64'(link_v_o), 64'h0);
    end

    // Round robin on E among P, W, N with fresh pointers.
    do_reset(7'd3, 7'd2);
    link_ready_i = 5'h1b;
    for (int s = 0; s < 2; s++) begin
      drive(PP,   mk(32'hA000_0000 + 32'(s), 7'd2, 7'd5));
      drive(PWst, mk(32'hB000_0000 + 32'(s), 7'd2, 7'd5));
      drive(PN,   mk(32'hC000_0000 + 32'(s), 7'd2, 7'd5));
      @(negedge clk);
    end
    link_v_i = '0;
    chk("rr_ready_full", 64'(link_ready_o), 64'h14);
    rr_exp[0] = mk(32'hA000_0000, 7'd2, 7'd5);
    rr_exp[1] = mk(32'hB000_0000, 7'd2, 7'd5);
    rr_exp[2] = mk(32'hC000_0000, 7'd2, 7'd5);
    rr_exp[3] = mk(32'hA000_0001, 7'd2, 7'd5);
    rr_exp[4] = mk(32'hB000_0001, 7'd2, 7'd5);
    rr_exp[5] = mk(32'hC000_0001, 7'd2, 7'd5);
    link_ready_i = 5'h1f;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("rr%0d_v", k), 64'(link_v_o[PE]), 64'd1);
      chk($sformatf("rr%0d_data", k), 64'(out_data(PE)), 64'(rr_exp[k]));
      @(negedge clk);
    end
    chk("rr_done", 64'(link_v_o), 64'h0);

    // Backpressure on E while W streams.
    do_reset(7'd3, 7'd2);
    for (int k = 0; k < 4; k++) bp[k] = mk(32'hD400_0000 + 32'(k), 7'd2, 7'd5);
    link_ready_i = 5'h1b;
    chk("bp_ready0", 64'(link_ready_o[PWst]), 64'd1);
    drive(PWst, bp[0]);
    @(negedge clk);
    chk("bp_ready1", 64'(link_ready_o[PWst]), 64'd1);
    chk("bp_v1", 64'(link_v_o[PE]), 64'd1);
    chk("bp_data1", 64'(out_data(PE)), 64'(bp[0]));
    drive(PWst, bp[1]);
    @(negedge clk);
    chk("bp_full", 64'(link_ready_o[PWst]), 64'd0);
    chk("bp_data2", 64'(out_data(PE)), 64'(bp[0]));
    drive(PWst, bp[2]);
    @(negedge clk);
    chk("bp_still_full", 64'(link_ready_o[PWst]), 64'd0);
    chk("bp_data3", 64'(out_data(PE)), 64'(bp[0]));
    link_v_i     = '0;
    link_ready_i = 5'h1f;
    @(negedge clk);
    chk("bp_drain_v", 64'(link_v_o[PE]), 64'd1);
    chk("bp_drain_data", 64'(out_data(PE)), 64'(bp[1]));
    chk("bp_ready_back", 64'(link_ready_o[PWst]), 64'd1);
    @(negedge clk);
    chk("bp_empty", 64'(link_v_o), 64'h0);

    // Mid-run reset with full FIFOs; new Y wraps.
    link_ready_i = 5'h1b;
    for (int s = 0; s < 2; s++) begin
      drive(PWst, mk(32'hE000_0000 + 32'(s), 7'd2, 7'd5));
      drive(PN,   mk(32'hF000_0000 + 32'(s), 7'd2, 7'd5));
      @(negedge clk);
    end
    link_v_i = '0;
    chk("mr_full", 64'(link_ready_o), 64'h15);
    reset_i = 1'b1;
    gx_i    = 7'd3;
    gy_i    = 7'd127;
    @(negedge clk);
    reset_i = 1'b0;
    chk("mr_v_in_reset", 64'(link_v_o), 64'h0);
    chk("mr_ready_in_reset", 64'(link_ready_o), 64'h0);
    @(negedge clk);
    chk("mr_v_after", 64'(link_v_o), 64'h0);
    chk("mr_ready_after", 64'(link_ready_o), 64'h1f);
    chk("y_wrap", 64'(gy_o), 64'd0);
    chk("x_relatch", 64'(gx_o), 64'd3);
    link_ready_i = 5'h1f;
    @(negedge clk);
    chk("mr_still_empty", 64'(link_v_o), 64'h0);
    pkt = mk(32'h7777_0001, 7'd2, 7'd3);
    drive(PWst, pkt);
    @(negedge clk);
    link_v_i = '0;
    chk("new_y_route_v", 64'(link_v_o), 64'(5'b01000));
    chk("new_y_route_data", 64'(out_data(PN)), 64'(pkt));
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
